// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - opcode constants, sequencer states and step limit shared by sequencer and decoder
package cpu_pkg;

  localparam int MAX_STEP = 4;

  localparam logic [3:0] NOP = 4'd0;
  localparam logic [3:0] LDA = 4'd1;
  localparam logic [3:0] ADD = 4'd2;
  localparam logic [3:0] SUB = 4'd3;
  localparam logic [3:0] STA = 4'd4;
  localparam logic [3:0] LDI = 4'd5;
  localparam logic [3:0] JMP = 4'd6;
  localparam logic [3:0] JC  = 4'd7;
  localparam logic [3:0] JZ  = 4'd8;
  localparam logic [3:0] OUT = 4'd14;
  localparam logic [3:0] HLT = 4'd15;

  typedef enum logic [1:0] {ST_RUN, ST_PAUSE, ST_HALT} seq_state_t;

endpackage

// File: rtl/cpu_sequencer_if.sv
// rtl/cpu_sequencer_if.sv - decoder/board-control signals between the sequencer and its environment
interface cpu_sequencer_if #(
  parameter int BUS_W  = 8,
  parameter int OPC_W  = 4,
  parameter int STEP_W = 3
) ();

  logic                   run;
  logic                   step_req;
  logic [BUS_W-1:0]       bus_in;
  logic                   ir_load;
  logic                   flag_load;
  logic                   hlt_req;
  logic                   alu_zero;
  logic                   alu_carry;
  logic [STEP_W-1:0]      step;
  logic [OPC_W-1:0]       instruction;
  logic [BUS_W-OPC_W-1:0] operand;
  logic                   zf;
  logic                   cf;
  logic                   cycle_en;
  logic                   halted;

  modport slave (
    input  run, step_req, bus_in, ir_load, flag_load, hlt_req, alu_zero, alu_carry,
    output step, instruction, operand, zf, cf, cycle_en, halted
  );

  modport master (
    output run, step_req, bus_in, ir_load, flag_load, hlt_req, alu_zero, alu_carry,
    input  step, instruction, operand, zf, cf, cycle_en, halted
  );

endinterface

// File: rtl/seq_step_len.sv
// rtl/seq_step_len.sv - opcode to last micro-step table; STEP_SKIP_EN shortens instructions that need fewer steps
module seq_step_len
  import cpu_pkg::*;
#(
  parameter int OPC_W         = 4,
  parameter int STEP_W        = 3,
  parameter int LAST_STEP_MAX = 4
) (
  input  logic [OPC_W-1:0]  opcode_i,
  output logic [STEP_W-1:0] last_step_o
);

`ifdef STEP_SKIP_EN
  always_comb begin
    last_step_o = STEP_W'(2);
    case (opcode_i)
      LDA, STA: last_step_o = STEP_W'(3);
      ADD, SUB: last_step_o = STEP_W'(LAST_STEP_MAX);
      default:  last_step_o = STEP_W'(2);
    endcase
  end
`else
  // Fixed-length instructions: the opcode does not matter.
  logic unused_opcode;
  assign unused_opcode = ^opcode_i;
  assign last_step_o   = STEP_W'(LAST_STEP_MAX);
`endif

endmodule

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - micro-step sequencer with IR, flags, halt latch and run/pause/single-step clock enable
// Instruction length comes from seq_step_len, which honours STEP_SKIP_EN.
module cpu_sequencer #(
  parameter int BUS_W    = 8,
  parameter int OPC_W    = 4,
  parameter int STEP_W   = 3,
  parameter int MAX_STEP = cpu_pkg::MAX_STEP
) (
  input logic            clk,
  input logic            rst,
  cpu_sequencer_if.slave sif
);
  import cpu_pkg::seq_state_t;
  import cpu_pkg::ST_RUN;
  import cpu_pkg::ST_PAUSE;
  import cpu_pkg::ST_HALT;

  seq_state_t             state_q, state_d;
  logic [STEP_W-1:0]      step_q, step_d;
  logic [OPC_W-1:0]       instr_q, instr_d;
  logic [BUS_W-OPC_W-1:0] opnd_q, opnd_d;
  logic                   zf_q, zf_d;
  logic                   cf_q, cf_d;
  logic                   step_req_q;
  logic                   step_pulse;
  logic                   cycle_en;
  logic [STEP_W-1:0]      last_step;

  seq_step_len #(
    .OPC_W        (OPC_W),
    .STEP_W       (STEP_W),
    .LAST_STEP_MAX(MAX_STEP)
  ) u_step_len (
    .opcode_i   (instr_q),
    .last_step_o(last_step)
  );

  assign step_pulse = sif.step_req & ~step_req_q;

  always_comb begin
    cycle_en = 1'b0;
    state_d  = state_q;
    step_d   = step_q;
    instr_d  = instr_q;
    opnd_d   = opnd_q;
    zf_d     = zf_q;
    cf_d     = cf_q;

    case (state_q)
      ST_RUN: begin
        cycle_en = 1'b1;
        if (!sif.run) state_d = ST_PAUSE;
      end
      ST_PAUSE: begin
        cycle_en = step_pulse;
        if (sif.run) state_d = ST_RUN;
      end
      default: begin
        cycle_en = 1'b0;
        state_d  = ST_HALT;
      end
    endcase

    if (cycle_en) begin
      // Halting freezes the step counter on the HLT step and overrides any run change.
      if (sif.hlt_req) begin
        state_d = ST_HALT;
      end else if (step_q == last_step) begin
        step_d = '0;
      end else begin
        step_d = step_q + STEP_W'(1);
      end
      if (sif.ir_load) {instr_d, opnd_d} = sif.bus_in;
      if (sif.flag_load) begin
        zf_d = sif.alu_zero;
        cf_d = sif.alu_carry;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_PAUSE;
      step_q     <= '0;
      instr_q    <= '0;
      opnd_q     <= '0;
      zf_q       <= 1'b0;
      cf_q       <= 1'b0;
      step_req_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      instr_q    <= instr_d;
      opnd_q     <= opnd_d;
      zf_q       <= zf_d;
      cf_q       <= cf_d;
      step_req_q <= sif.step_req;
    end
  end

  assign sif.step        = step_q;
  assign sif.instruction = instr_q;
  assign sif.operand     = opnd_q;
  assign sif.zf          = zf_q;
  assign sif.cf          = cf_q;
  assign sif.cycle_en    = cycle_en;
  assign sif.halted      = (state_q == ST_HALT);

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - self-checking bench for cpu_sequencer: vector table, directed corners, random vs model
module tb_cpu_sequencer;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cpu_sequencer_if #(.BUS_W(8), .OPC_W(4), .STEP_W(3)) sif ();

  cpu_sequencer #(.BUS_W(8), .OPC_W(4), .STEP_W(3), .MAX_STEP(4)) dut (
    .clk(clk),
    .rst(rst),
    .sif(sif)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: mode 0=run, 1=pause, 2=halt.
  int         m_mode  = 1;
  int         m_step  = 0;
  logic [3:0] m_instr = 4'd0;
  logic [3:0] m_opnd  = 4'd0;
  bit         m_zf, m_cf, m_prev, m_valid;

  logic [2:0] o_step;
  logic [3:0] o_instr, o_opnd;
  logic       o_zf, o_cf, o_en, o_halt;

  typedef struct {
    logic       run;
    logic       il;
    logic [7:0] bus;
    logic [2:0] e_step;
    logic [3:0] e_instr;
    logic [3:0] e_opnd;
    logic       e_en;
  } vec_t;

  vec_t tbl[8];

  function automatic int ls(input logic [3:0] op);
`ifdef STEP_SKIP_EN
    if (op == LDA || op == STA) return 3;
    if (op == ADD || op == SUB) return 4;
    return 2;
`else
    return 4 + 0 * int'(op);
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic cyc(input bit r, input bit run_v, input bit req, input logic [7:0] bus,
                     input bit il, input bit fl, input bit hlt, input bit az, input bit ac);
    bit en_m;
    rst = r; sif.run = run_v; sif.step_req = req; sif.bus_in = bus;
    sif.ir_load = il; sif.flag_load = fl; sif.hlt_req = hlt;
    sif.alu_zero = az; sif.alu_carry = ac;
    @(negedge clk);
    o_step = sif.step; o_instr = sif.instruction; o_opnd = sif.operand;
    o_zf = sif.zf; o_cf = sif.cf; o_en = sif.cycle_en; o_halt = sif.halted;
    en_m = (m_mode == 0) || (m_mode == 1 && req && !m_prev);
    if (m_valid)
      check("model {step,instr,opnd,zf,cf,en,halted}",
            {o_step, o_instr, o_opnd, o_zf, o_cf, o_en, o_halt},
            {3'(m_step), m_instr, m_opnd, m_zf, m_cf, en_m, (m_mode == 2)});
    if (r) begin
      m_mode = 1; m_step = 0; m_instr = 4'd0; m_opnd = 4'd0;
      m_zf = 1'b0; m_cf = 1'b0; m_prev = 1'b0; m_valid = 1'b1;
    end else if (m_valid) begin
      if (en_m) begin
        if (hlt) m_mode = 2;
        else begin
          m_step = (m_step == ls(m_instr)) ? 0 : m_step + 1;
          if (m_mode == 1 && run_v) m_mode = 0;
          else if (m_mode == 0 && !run_v) m_mode = 1;
        end
        if (il) {m_instr, m_opnd} = bus;
        if (fl) begin m_zf = az; m_cf = ac; end
      end else if (m_mode == 1 && run_v) begin
        m_mode = 0;
      end
      m_prev = req;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit run_v);
    cyc(1'b0, run_v, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic to_fetch();
    for (int k = 0; k < 8 && m_step != 0; k++) idle(1'b1);
    check("to_fetch step", sif.step, 0);
  endtask

  task automatic exec_instr(input logic [7:0] ir, input bit fl, input bit az, input bit ac);
    int k = 0;
    do begin
      cyc(1'b0, 1'b1, 1'b0, ir, (m_step == 1), (fl && m_step == 4), 1'b0, az, ac);
      k++;
    end while (m_step != 0 && k < 12);
    check("exec_instr end step", sif.step, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    int bad;

    tbl[0] = '{1'b1, 1'b0, 8'h00, 3'd0, 4'd0, 4'd0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 8'h00, 3'd0, 4'd0, 4'd0, 1'b1};
    tbl[2] = '{1'b1, 1'b1, 8'h51, 3'd1, 4'd0, 4'd0, 1'b1};
    tbl[3] = '{1'b1, 1'b0, 8'h00, 3'd2, 4'd5, 4'd1, 1'b1};
`ifdef STEP_SKIP_EN
    tbl[4] = '{1'b1, 1'b0, 8'h00, 3'd0, 4'd5, 4'd1, 1'b1};
    tbl[5] = '{1'b1, 1'b0, 8'h00, 3'd1, 4'd5, 4'd1, 1'b1};
    tbl[6] = '{1'b1, 1'b0, 8'h00, 3'd2, 4'd5, 4'd1, 1'b1};
    tbl[7] = '{1'b1, 1'b0, 8'h00, 3'd0, 4'd5, 4'd1, 1'b1};
`else
    tbl[4] = '{1'b1, 1'b0, 8'h00, 3'd3, 4'd5, 4'd1, 1'b1};
    tbl[5] = '{1'b1, 1'b0, 8'h00, 3'd4, 4'd5, 4'd1, 1'b1};
    tbl[6] = '{1'b1, 1'b0, 8'h00, 3'd0, 4'd5, 4'd1, 1'b1};
    tbl[7] = '{1'b1, 1'b0, 8'h00, 3'd1, 4'd5, 4'd1, 1'b1};
`endif

    // Reset state and LDI step sequence
    do_reset();
    check("reset {step,instr,opnd,zf,cf,halted}",
          {sif.step, sif.instruction, sif.operand, sif.zf, sif.cf, sif.halted}, 0);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, tbl[i].run, 1'b0, tbl[i].bus, tbl[i].il, 1'b0, 1'b0, 1'b0, 1'b0);
      check($sformatf("tbl[%0d] step", i), o_step, tbl[i].e_step);
      check($sformatf("tbl[%0d] instruction", i), o_instr, tbl[i].e_instr);
      check($sformatf("tbl[%0d] operand", i), o_opnd, tbl[i].e_opnd);
      check($sformatf("tbl[%0d] cycle_en", i), o_en, tbl[i].e_en);
    end

    // ADD with flag load, then flags hold through LDI
    to_fetch();
    exec_instr(8'h2A, 1'b1, 1'b1, 1'b1);
    check("add zf", sif.zf, 1);
    check("add cf", sif.cf, 1);
    exec_instr(8'h5F, 1'b0, 1'b0, 1'b0);
    check("ldi keeps zf", sif.zf, 1);
    check("ldi keeps cf", sif.cf, 1);
    check("ldi instr/opnd", {sif.instruction, sif.operand}, 8'h5F);

    // Single-step pulses in PAUSE
    do_reset();
    cnt = 0;
    for (int p = 0; p < 3; p++)
      for (int c = 0; c < 5; c++) begin
        cyc(1'b0, 1'b0, (c < 2), 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cnt += int'(o_en);
      end
    check("three pulses enable count", cnt, 3);
    check("three pulses step", sif.step, 3 % (ls(NOP) + 1));
    cnt = 0;
    for (int c = 0; c < 8; c++) begin
      cyc(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      cnt += int'(o_en);
    end
    check("held step_req enable count", cnt, 1);
    idle(1'b0);

    // HLT at step 2 with run dropping the same cycle
    do_reset();
    idle(1'b1);
    idle(1'b1);
    cyc(1'b0, 1'b1, 1'b0, 8'hF0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("hlt step before edge", o_step, 2);
    check("hlt halted", sif.halted, 1);
    check("hlt cycle_en", sif.cycle_en, 0);
    check("hlt step frozen", sif.step, 2);
    bad = 0;
    for (int c = 0; c < 8; c++) begin
      cyc(1'b0, 1'b1, c[0], 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (o_en !== 1'b0 || o_step !== 3'd2 || o_halt !== 1'b1) bad++;
    end
    check("halt ignores step_req/run", bad, 0);
    do_reset();
    check("rst clears halted", sif.halted, 0);

    // Reset in the middle of LDA
    idle(1'b1);
    idle(1'b1);
    cyc(1'b0, 1'b1, 1'b0, 8'h13, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("lda step before rst", o_step, 3);
    check("lda flags before rst", {o_zf, o_cf}, 2'b11);
    idle(1'b1);
    check("after rst {step,instr,zf,cf,en}", {o_step, o_instr, o_zf, o_cf, o_en}, 0);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++)
      cyc(($urandom_range(0, 59) == 0), ($urandom_range(0, 7) != 0), 1'($urandom),
          8'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 39) == 0), 1'($urandom), 1'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
